// File: rtl/seq_det_pkg.sv
// Shared constants and the elaboration-time transition function for the
// overlapping Mealy sequence detector.
package seq_det_pkg;

  localparam int         DEF_LEN     = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1010;
  localparam int         MAX_LEN     = 16;

  // KMP-style next state: longest proper prefix of the pattern that is a suffix
  // of (first k pattern bits, then b). Bit i of the pattern, MSB-first, is
  // pattern[len-1-i]; the pattern is right-aligned in the MAX_LEN vector.
  function automatic int next_state(input int k, input logic b,
                                    input logic [MAX_LEN-1:0] pattern,
                                    input int len);
    int   jmax;
    int   res;
    int   pos;
    logic found;
    logic ok;
    logic sb;
    res   = 0;
    found = 1'b0;
    jmax  = (k + 1 < len) ? k + 1 : len - 1;
    for (int j = jmax; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        pos = k + 1 - j + i;
        sb  = (pos == k) ? b : pattern[4'(len - 1 - pos)];
        if (pattern[4'(len - 1 - i)] != sb) ok = 1'b0;
      end
      if (ok && !found) begin
        res   = j;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_overlap_mealy.sv
// Serial pattern detector, Mealy output, overlapping matches. The transition
// table is a constant built from PATTERN at elaboration.
module seq_det_overlap_mealy
  import seq_det_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  localparam int                 SW      = $clog2(LEN);
  localparam int                 NENT    = 2 * LEN;
  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);

  // Entry (2*k + b) holds the successor of state k on input bit b.
  function automatic logic [NENT*SW-1:0] build_table();
    logic [NENT*SW-1:0] t;
    t = '0;
    for (int k = 0; k < LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        t[(2*k + b)*SW +: SW] = SW'(next_state(k, b[0], PAT_EXT, LEN));
      end
    end
    return t;
  endfunction

  localparam logic [NENT*SW-1:0] NS_TABLE = build_table();

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  // Codes at or above LEN never match the loop and fall back to S0.
  always_comb begin
    state_d = '0;
    for (int k = 0; k < LEN; k++) begin
      if (state_q == SW'(k)) begin
        state_d = data_in ? NS_TABLE[(2*k + 1)*SW +: SW]
                          : NS_TABLE[(2*k)*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign data_out = !rst && (state_q == SW'(LEN - 1)) && (data_in == PATTERN[0]);

endmodule

// File: tb/tb_seq_det_overlap_mealy.sv
// Bench for seq_det_overlap_mealy: directed scenarios plus random bits against
// a "last LEN bits equal the pattern" reference.
module tb_seq_det_overlap_mealy;

  localparam int          LEN4 = 4;
  localparam logic [15:0] PAT4 = 16'b1010;
  localparam int          LEN3 = 3;
  localparam logic [15:0] PAT3 = 16'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b1;
  logic data_in3 = 1'b1;
  logic data_out;
  logic data_out3;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] hist4 = '0;
  logic [15:0] hist3 = '0;
  int          cnt4 = 0;
  int          cnt3 = 0;

  always #5 clk = ~clk;

  seq_det_overlap_mealy u_dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  seq_det_overlap_mealy #(.LEN(LEN3), .PATTERN(3'b111)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in3),
    .data_out (data_out3)
  );

  // A match is simply: at least len-1 bits since reset, and those plus b equal the pattern.
  function automatic logic model_match(input logic [15:0] h, input int c, input logic b,
                                       input logic [15:0] pat, input int len);
    logic [15:0] w;
    logic [15:0] m;
    w = {h[14:0], b};
    m = (16'd1 << len) - 16'd1;
    return (c >= len - 1) && ((w & m) == (pat & m));
  endfunction

  // Drive one bit for one clock; report observed and reference outputs mid-cycle.
  task automatic step(input logic b, input logic r,
                      output logic o4, output logic e4,
                      output logic o3, output logic e3);
    rst = r;
    data_in = b;
    data_in3 = b;
    @(negedge clk);
    e4 = !r && model_match(hist4, cnt4, b, PAT4, LEN4);
    e3 = !r && model_match(hist3, cnt3, b, PAT3, LEN3);
    o4 = data_out;
    o3 = data_out3;
    @(posedge clk);
    if (r) begin
      hist4 = '0; cnt4 = 0; hist3 = '0; cnt3 = 0;
    end else begin
      hist4 = {hist4[14:0], b}; cnt4++;
      hist3 = {hist3[14:0], b}; cnt3++;
    end
    #1;
  endtask

  task automatic do_reset();
    logic o4, e4, o3, e3;
    step(1'b0, 1'b1, o4, e4, o3, e3);
  endtask

  task automatic test_reset();
    logic o4, e4, o3, e3;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, o4, e4, o3, e3);
      tests_run++;
      if (o4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: data_out=%b expected 0", i, o4);
      end
      tests_run++;
      if (o3 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset cycle %0d (LEN3): data_out=%b expected 0", i, o3);
      end
    end
  endtask

  task automatic test_single_match();
    logic o4, e4, o3, e3;
    logic seq [6] = '{1, 0, 1, 0, 0, 0};
    logic ex  [6] = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 1'b0, o4, e4, o3, e3);
      tests_run++;
      if (o4 !== ex[i]) begin
        tests_failed++;
        $display("FAIL single bit %0d: data_out=%b expected %b", i + 1, o4, ex[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic o4, e4, o3, e3;
    logic seq [14] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1};
    logic ex  [14] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(seq[i], 1'b0, o4, e4, o3, e3);
      tests_run++;
      if (o4 !== ex[i]) begin
        tests_failed++;
        $display("FAIL overlap bit %0d: data_out=%b expected %b", i + 1, o4, ex[i]);
      end
    end
  endtask

  task automatic test_near_miss();
    logic o4, e4, o3, e3;
    logic seq [10] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(seq[i], 1'b0, o4, e4, o3, e3);
      tests_run++;
      if (o4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL near_miss bit %0d: data_out=%b expected 0", i + 1, o4);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic o4, e4, o3, e3;
    logic seq [9] = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
    logic rs  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic ex  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(seq[i], rs[i], o4, e4, o3, e3);
      tests_run++;
      if (o4 !== ex[i]) begin
        tests_failed++;
        $display("FAIL reset_mid step %0d: data_out=%b expected %b", i + 1, o4, ex[i]);
      end
    end
  endtask

  task automatic test_param();
    logic o4, e4, o3, e3;
    logic ex [5] = '{0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, o4, e4, o3, e3);
      tests_run++;
      if (o3 !== ex[i]) begin
        tests_failed++;
        $display("FAIL param111 bit %0d: data_out=%b expected %b", i + 1, o3, ex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic o4, e4, o3, e3;
    logic b;
    logic r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 29) == 0);
      step(b, r, o4, e4, o3, e3);
      tests_run++;
      if (o4 !== e4) begin
        tests_failed++;
        $display("FAIL random1010 cycle %0d: data_out=%b expected %b", i, o4, e4);
      end
      tests_run++;
      if (o3 !== e3) begin
        tests_failed++;
        $display("FAIL random111 cycle %0d: data_out=%b expected %b", i, o3, e3);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_match();
    test_overlap();
    test_near_miss();
    test_reset_mid();
    test_param();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
